// File: rtl/cond_pkg.sv
// Shared definitions for the conditional execute stage: condition codes,
// NZCV flag bit positions and FlagW bit positions.
package cond_pkg;

    // Condition field encodings
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // NZCV bit positions within Flags / ALUFlags
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    // FlagW bit positions
    localparam int unsigned FW_NZ = 1;
    localparam int unsigned FW_CV = 0;

endpackage

// File: rtl/cond_check.sv
// Combinational condition evaluator: decides whether an instruction with
// condition field Cond executes given the current NZCV flags.
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       CondEx
);

    logic n, z, c, v;

    assign n = Flags[FLAG_N];
    assign z = Flags[FLAG_Z];
    assign c = Flags[FLAG_C];
    assign v = Flags[FLAG_V];

    // Decode the condition table against the flags
    always_comb begin
        CondEx = 1'b0;
        unique case (Cond)
            COND_EQ: CondEx = z;
            COND_NE: CondEx = !z;
            COND_CS: CondEx = c;
            COND_CC: CondEx = !c;
            COND_MI: CondEx = n;
            COND_PL: CondEx = !n;
            COND_VS: CondEx = v;
            COND_VC: CondEx = !v;
            COND_HI: CondEx = c && !z;
            COND_LS: CondEx = !c || z;
            COND_GE: CondEx = (n == v);
            COND_LT: CondEx = (n != v);
            COND_GT: CondEx = !z && (n == v);
            COND_LE: CondEx = z || (n != v);
            COND_AL: CondEx = 1'b1;
            COND_NV: CondEx = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_exec_stage.sv
// Execute-stage conditional logic: one-entry EX register with valid/ready
// handshake, condition check against NZCV, gating of PCSrc/RegWrite/MemWrite
// and NZCV update on retirement.
// Optional build macro COND_BRANCH_FLUSH_EN: a taken branch retiring on the
// same edge as an acceptance loads the accepted slot as invalid.
module cond_exec_stage
    import cond_pkg::*;
#(
    parameter logic [3:0] FLAG_RESET = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       InValid,
    output logic       InReady,
    input  logic [3:0] Cond,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       RegW,
    input  logic       MemW,
    input  logic [3:0] ALUFlags,
    output logic       OutValid,
    input  logic       OutReady,
    output logic       PCSrc,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       CondEx,
    output logic [3:0] Flags
);

    logic       ex_valid_q, ex_valid_d;
    logic [3:0] ex_cond_q, ex_cond_d;
    logic [1:0] ex_flagw_q, ex_flagw_d;
    logic       ex_pcs_q, ex_pcs_d;
    logic       ex_regw_q, ex_regw_d;
    logic       ex_memw_q, ex_memw_d;
    logic [3:0] flags_q, flags_d;

    logic cond_pass;
    logic fire_in;
    logic fire_out;
    logic load_valid;

    cond_check u_cond_check (
        .Cond   (ex_cond_q),
        .Flags  (flags_q),
        .CondEx (cond_pass)
    );

    // Handshake and gated outputs, all driven from registered state
    always_comb begin
        InReady  = !ex_valid_q || OutReady;
        OutValid = ex_valid_q;
        CondEx   = ex_valid_q && cond_pass;
        PCSrc    = CondEx && ex_pcs_q;
        RegWrite = CondEx && ex_regw_q;
        MemWrite = CondEx && ex_memw_q;
        Flags    = flags_q;
        fire_in  = InValid && InReady;
        fire_out = ex_valid_q && OutReady;
`ifdef COND_BRANCH_FLUSH_EN
        // The slot behind a taken branch is wrong-path and is dropped here
        load_valid = !(fire_out && PCSrc);
`else
        load_valid = 1'b1;
`endif
    end

    // Next state of the EX register and the NZCV register
    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_cond_d  = ex_cond_q;
        ex_flagw_d = ex_flagw_q;
        ex_pcs_d   = ex_pcs_q;
        ex_regw_d  = ex_regw_q;
        ex_memw_d  = ex_memw_q;
        flags_d    = flags_q;

        if (fire_in) begin
            ex_valid_d = load_valid;
            ex_cond_d  = Cond;
            ex_flagw_d = FlagW;
            ex_pcs_d   = PCS;
            ex_regw_d  = RegW;
            ex_memw_d  = MemW;
        end else if (fire_out) begin
            ex_valid_d = 1'b0;
        end

        // Squashed instructions never touch the flags
        if (fire_out && CondEx) begin
            if (ex_flagw_q[FW_NZ]) begin
                flags_d[FLAG_N] = ALUFlags[FLAG_N];
                flags_d[FLAG_Z] = ALUFlags[FLAG_Z];
            end
            if (ex_flagw_q[FW_CV]) begin
                flags_d[FLAG_C] = ALUFlags[FLAG_C];
                flags_d[FLAG_V] = ALUFlags[FLAG_V];
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_q <= 1'b0;
            ex_cond_q  <= 4'b0000;
            ex_flagw_q <= 2'b00;
            ex_pcs_q   <= 1'b0;
            ex_regw_q  <= 1'b0;
            ex_memw_q  <= 1'b0;
            flags_q    <= FLAG_RESET;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_cond_q  <= ex_cond_d;
            ex_flagw_q <= ex_flagw_d;
            ex_pcs_q   <= ex_pcs_d;
            ex_regw_q  <= ex_regw_d;
            ex_memw_q  <= ex_memw_d;
            flags_q    <= flags_d;
        end
    end

endmodule
